// File: rtl/regfile_scoreboard.sv
// Multi-port register file with registered read ports and a per-register pending scoreboard.
// Optional write-first forwarding on same-edge read/write is enabled by defining RF_BYPASS_EN.
module regfile_scoreboard #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] read1,
  input  logic [ADDR_W-1:0] read2,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2,
  output logic              rd_valid,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              resv_en,
  input  logic [ADDR_W-1:0] resv_reg,
  output logic              busy1,
  output logic              busy2
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_next;
  logic                write_ok;
  logic                resv_ok;
  logic [DATA_W-1:0]   rd_value1;
  logic [DATA_W-1:0]   rd_value2;

  // Register 0 swallows writes and reservations when hardwired to zero.
  assign write_ok = reg_write && !((ZERO_REG != 0) && (write_reg == '0));
  assign resv_ok  = resv_en   && !((ZERO_REG != 0) && (resv_reg  == '0));

  // NOTE: always_comb outputs get a full default first so no latch is inferred.
  always_comb begin
    pending_next = pending;
    if (write_ok) pending_next[write_reg] = 1'b0;
    // Applied after the clear so a same-cycle reserve of the written register wins.
    if (resv_ok)  pending_next[resv_reg]  = 1'b1;
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] value;
    value = regs[addr];
`ifdef RF_BYPASS_EN
    if (reg_write && (write_reg == addr)) value = write_data;
`endif
    if ((ZERO_REG != 0) && (addr == '0)) value = '0;
    return value;
  endfunction

  assign rd_value1 = read_port(read1);
  assign rd_value2 = read_port(read2);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      // NOTE: the file is cleared by reset, so it maps to flops rather than a RAM macro.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      pending  <= '0;
      data1    <= '0;
      data2    <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (write_ok) regs[write_reg] <= write_data;
      pending  <= pending_next;
      rd_valid <= rd_en;
      if (rd_en) begin
        data1 <= rd_value1;
        data2 <= rd_value2;
      end
    end
  end

  // Busy reflects the scoreboard as of the last edge, never the current request.
  assign busy1 = pending[read1] && !((ZERO_REG != 0) && (read1 == '0));
  assign busy2 = pending[read2] && !((ZERO_REG != 0) && (read2 == '0));

endmodule
